conv_result_sequencer: RTL and testbench

Control and capture stage directly downstream of the float16 convolution unit.
- Per window: accepts a start handshake and pulses the window-load strobe so upstream registers the image and filter words.
- Holds the conv unit in reset, then releases it for exactly D*F*F+PE_LATENCY cycles and captures the float16 result.
- Presents the result on a valid/ready output with frame-position tracking.
- Downstream consumers are pooling and the output buffer.

---
 rtl/conv_result_sequencer_if.sv | 52 +++++
 rtl/conv_result_sequencer.sv | 160 ++++++++++++++++
 tb/tb_conv_result_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_result_sequencer_if.sv
// rtl/conv_result_sequencer_if.sv - window handshake, conv-unit control and result stream bundle
interface conv_result_sequencer_if #(
    parameter int DATA_WIDTH = 16
);

    // Upstream window handshake
    logic                  in_valid;
    logic                  in_ready;
    logic                  win_load;

    // Conv unit control and result
    logic                  pe_reset;
    logic [DATA_WIDTH-1:0] conv_result;

    // Result stream to pooling / output buffer
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    // Status
    logic                  busy;

    // Upstream/downstream environment side
    modport master (
        output in_valid,
        output conv_result,
        output out_ready,
        input  in_ready,
        input  win_load,
        input  pe_reset,
        input  out_data,
        input  out_valid,
        input  out_last,
        input  busy
    );

    // Sequencer side
    modport slave (
        input  in_valid,
        input  conv_result,
        input  out_ready,
        output in_ready,
        output win_load,
        output pe_reset,
        output out_data,
        output out_valid,
        output out_last,
        output busy
    );

endinterface

// File: rtl/conv_result_sequencer.sv
// rtl/conv_result_sequencer.sv - conv unit window sequencer and result capture; optional ReLU via CONV_SEQ_RELU_EN
module conv_result_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int F          = 5,
    parameter int PE_LATENCY = 2,
    parameter int OUT_COUNT  = 576
) (
    input  logic                    clk,
    input  logic                    reset,
    conv_result_sequencer_if.slave  bus
);

    // Cycles the conv unit must run out of reset before its result is stable
    localparam int N     = D * F * F + PE_LATENCY;
    localparam int CNT_W = $clog2(N + 1);
    localparam int POS_W = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(OUT_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ACCUM = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [CNT_W-1:0]      r_cnt;
    logic [POS_W-1:0]      r_pos;

    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;

    logic                  w_in_ready;
    logic                  w_win_load;
    logic                  w_pe_reset;
    logic                  w_capture;
    logic                  w_release;
    logic [DATA_WIDTH-1:0] w_capture_data;

    // Result shaping applied at capture; both variants are purely combinational so latency matches
`ifdef CONV_SEQ_RELU_EN
    always_comb begin
        w_capture_data = bus.conv_result;
        if (bus.conv_result[DATA_WIDTH-1]) begin
            w_capture_data = '0;
        end
    end
`else
    always_comb begin
        w_capture_data = bus.conv_result;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and per-state control strobes
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_win_load   = 1'b0;
        w_pe_reset   = 1'b1;
        w_capture    = 1'b0;
        w_release    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_win_load   = 1'b1;
                    w_next_state = S_CLEAR;
                end
            end

            S_CLEAR: begin
                w_next_state = S_ACCUM;
            end

            S_ACCUM: begin
                w_pe_reset = 1'b0;
                if (r_cnt == CNT_LAST) begin
                    w_capture    = 1'b1;
                    w_next_state = S_HOLD;
                end
            end

            S_HOLD: begin
                if (bus.out_ready) begin
                    w_release    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Run-length counter: cleared in CLEAR, counts every ACCUM cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_cnt <= '0;
        end else if (r_state == S_ACCUM) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Frame position, advanced when a result is handed downstream
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pos <= '0;
        end else if (w_release) begin
            if (r_pos == POS_LAST) begin
                r_pos <= '0;
            end else begin
                r_pos <= r_pos + POS_W'(1);
            end
        end
    end

    // Output register: capture at end of ACCUM, hold through HOLD, drop on acceptance
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_capture) begin
            r_out_data  <= w_capture_data;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_pos == POS_LAST);
        end else if (w_release) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.win_load  = w_win_load;
    assign bus.pe_reset  = w_pe_reset;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_conv_result_sequencer.sv
// tb/tb_conv_result_sequencer.sv - scoreboard bench for conv_result_sequencer (default and D=3,F=3 builds)
module tb_conv_result_sequencer;

    localparam int DW   = 16;
    localparam int NA   = 1 * 5 * 5 + 2;
    localparam int NB   = 3 * 3 * 3 + 2;
    localparam int OUTS = 576;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    conv_result_sequencer_if #(.DATA_WIDTH(DW)) bus_a ();
    conv_result_sequencer_if #(.DATA_WIDTH(DW)) bus_b ();

    conv_result_sequencer #(
        .DATA_WIDTH (DW),
        .D          (1),
        .F          (5),
        .PE_LATENCY (2),
        .OUT_COUNT  (OUTS)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    conv_result_sequencer #(
        .DATA_WIDTH (DW),
        .D          (3),
        .F          (3),
        .PE_LATENCY (2),
        .OUT_COUNT  (OUTS)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int model_pos = 0;
    logic [DW-1:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] relu_model(input logic [DW-1:0] v);
`ifdef CONV_SEQ_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // One window on dut_a; in_valid stays high throughout, hold = cycles out_ready is kept low in HOLD
    task automatic window_a(input logic [DW-1:0] val, input int hold, input bit b2b);
        int c, t, pe_low, pe_first, wl_extra;
        logic [DW-1:0] exp;
        bus_a.in_valid  = 1'b1;
        bus_a.out_ready = (hold == 0);
        t = 0;
        @(negedge clk);
        while (!bus_a.in_ready) begin
            t++;
            if (t > 200) begin
                check("accept_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
        if (b2b) check("b2b_accept_gap", t, 0);
        check("win_load_c0", bus_a.win_load, 1);
        sb_q.push_back(relu_model(val));
        c = 0; pe_low = 0; pe_first = -1; wl_extra = 0;
        forever begin
            @(posedge clk); #1;
            c++;
            bus_a.conv_result = (c == NA + 1) ? val : ~val;
            @(negedge clk);
            if (bus_a.win_load) wl_extra++;
            if (!bus_a.pe_reset) begin
                pe_low++;
                if (pe_first < 0) pe_first = c;
            end
            if (bus_a.out_valid || c > 200) break;
        end
        check("out_valid_cycle", c, NA + 2);
        check("pe_low_count", pe_low, NA);
        check("pe_low_first", pe_first, 2);
        check("win_load_extra", wl_extra, 0);
        check("in_ready_hold", bus_a.in_ready, 0);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        check("out_data", bus_a.out_data, exp);
        check("out_last", bus_a.out_last, (model_pos == OUTS - 1));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            bus_a.conv_result = DW'($urandom);
            @(negedge clk);
            check("hold_valid", bus_a.out_valid, 1);
            check("hold_data", bus_a.out_data, exp);
            check("hold_in_ready", bus_a.in_ready, 0);
            check("hold_win_load", bus_a.win_load, 0);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            bus_a.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("release_valid", bus_a.out_valid, 0);
        check("release_last", bus_a.out_last, 0);
        check("release_busy", bus_a.busy, 0);
        model_pos = (model_pos == OUTS - 1) ? 0 : model_pos + 1;
    endtask

    // Window on dut_a aborted by reset during ACCUM cycle 10
    task automatic abort_a();
        int t;
        bus_a.in_valid  = 1'b1;
        bus_a.out_ready = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus_a.in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        check("abort_accept", bus_a.win_load, 1);
        bus_a.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("abort_valid", bus_a.out_valid, 0);
        check("abort_pe_reset", bus_a.pe_reset, 1);
        check("abort_busy", bus_a.busy, 0);
        check("abort_data", bus_a.out_data, 0);
        reset = 1'b1;
        model_pos = 0;
    endtask

    // Single window on the D=3,F=3 instance
    task automatic window_b(input logic [DW-1:0] val);
        int c, t, pe_low;
        bus_b.in_valid  = 1'b1;
        bus_b.out_ready = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus_b.in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        check("b_win_load", bus_b.win_load, 1);
        c = 0; pe_low = 0;
        forever begin
            @(posedge clk); #1;
            c++;
            bus_b.in_valid    = 1'b0;
            bus_b.conv_result = (c == NB + 1) ? val : ~val;
            @(negedge clk);
            if (!bus_b.pe_reset) pe_low++;
            if (bus_b.out_valid || c > 200) break;
        end
        check("b_out_valid_cycle", c, NB + 2);
        check("b_pe_low_count", pe_low, NB);
        check("b_out_data", bus_b.out_data, relu_model(val));
        @(posedge clk); #1;
        check("b_release_valid", bus_b.out_valid, 0);
    endtask

    initial begin
        reset             = 1'b0;
        bus_a.in_valid    = 1'b0;
        bus_a.out_ready   = 1'b0;
        bus_a.conv_result = '0;
        bus_b.in_valid    = 1'b0;
        bus_b.out_ready   = 1'b0;
        bus_b.conv_result = '0;

        repeat (3) @(negedge clk);
        check("rst_out_valid", bus_a.out_valid, 0);
        check("rst_out_last", bus_a.out_last, 0);
        check("rst_out_data", bus_a.out_data, 0);
        check("rst_pe_reset", bus_a.pe_reset, 1);
        check("rst_busy", bus_a.busy, 0);
        check("rst_in_ready", bus_a.in_ready, 1);
        @(posedge clk); #1;
        reset = 1'b1;

        window_a(16'h4500, 10, 1'b0);
        window_a(16'hC200, 0, 1'b1);
        window_a(16'h8000, 0, 1'b1);
        window_a(16'h3C00, 0, 1'b1);

        // Fill out the remainder of the frame plus one wrapped window
        for (int i = 0; i < OUTS + 1 - 4; i++) begin
            window_a(DW'($urandom), 0, 1'b1);
        end

        abort_a();

        window_a(16'h4500, 0, 1'b0);
        for (int i = 1; i < OUTS; i++) begin
            window_a(DW'($urandom), 0, 1'b1);
        end
        bus_a.in_valid = 1'b0;

        window_b(16'h4a00);
        window_b(16'hC200);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
